// File: rtl/pkt_mac_rewrite_out_pkg.sv
// Shared constants, FSM encoding and helpers for the packet MAC rewrite output stage.
package pkt_mac_rewrite_out_pkg;

  localparam int PKT_W  = 134;
  localparam int META_W = 128;
  localparam int MAC_W  = 48;
  localparam int TAG_HI = 133;

  // Beat tag values in i_pkt/o_pkt [133:132]
  localparam logic [1:0] TAG_BODY   = 2'b00;
  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  // Metadata field offsets
  localparam int DMAC_HI     = 127;
  localparam int SMAC_HI     = 79;
  localparam int REWRITE_BIT = 31;
  localparam int DROP_BIT    = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // A beat opens a packet when it is tagged head or head+tail.
  function automatic logic tag_is_head(input logic [1:0] tag);
    return (tag != TAG_BODY) && (tag != TAG_TAIL);
  endfunction

  // A beat closes a packet when it is tagged tail or head+tail.
  function automatic logic tag_is_tail(input logic [1:0] tag);
    return (tag == TAG_TAIL) || (tag == TAG_SINGLE);
  endfunction

  // Overwrite the dst/src MAC bytes of a head beat; tag, count and the rest pass through.
  function automatic logic [PKT_W-1:0] mac_rewrite(input logic [PKT_W-1:0] beat,
                                                   input logic [MAC_W-1:0] dmac,
                                                   input logic [MAC_W-1:0] smac);
    logic [PKT_W-1:0] res;
    res = beat;
    res[DMAC_HI -: MAC_W] = dmac;
    res[SMAC_HI -: MAC_W] = smac;
    return res;
  endfunction

endpackage

// File: rtl/pkt_mac_rewrite_out_sfifo_fwft.sv
// Synchronous show-ahead FIFO. rd_data always presents the oldest entry while
// !empty. A write into a full FIFO is ignored unless a read happens the same cycle.
module sfifo_fwft #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_ok;
  logic         rd_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer advance on accepted writes and reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pkt_mac_rewrite_out.sv
// Output stage: pairs buffered packet beats with per-packet metadata in arrival
// order, rewrites dst/src MAC on the head beat or drops the whole packet.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a packet beat and a metadata word; one-cycle gap
//   ST_SEND | forwarding beats of the current packet to o_pkt
//   ST_DROP | consuming beats of the current packet with no output
module pkt_mac_rewrite_out
  import pkt_mac_rewrite_out_pkg::*;
#(
  parameter int PKT_AW  = 9,
  parameter int META_AW = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pkt_valid,
  input  logic [PKT_W-1:0]  i_pkt,
  input  logic              i_meta_valid,
  input  logic [META_W-1:0] i_meta,
  output logic              o_pkt_valid,
  output logic [PKT_W-1:0]  o_pkt,
  output logic              o_pkt_ovf,
  output logic              o_meta_ovf
);

  state_t             state;
  logic [PKT_W-1:0]   pkt_head;
  logic [META_W-1:0]  meta_rd;
  logic               pkt_empty, pkt_full, pkt_pop;
  logic               meta_empty, meta_full, meta_pop;
  logic               beat_head, beat_tail;
  logic               first_beat;
  logic               meta_rewrite;
  logic [MAC_W-1:0]   meta_dmac, meta_smac;
  logic               meta_rsvd_unused;

  sfifo_fwft #(.W(PKT_W), .AW(PKT_AW)) u_pkt_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (i_pkt_valid),
    .wr_data (i_pkt),
    .rd_en   (pkt_pop),
    .rd_data (pkt_head),
    .full    (pkt_full),
    .empty   (pkt_empty)
  );

  sfifo_fwft #(.W(META_W), .AW(META_AW)) u_meta_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (i_meta_valid),
    .wr_data (i_meta),
    .rd_en   (meta_pop),
    .rd_data (meta_rd),
    .full    (meta_full),
    .empty   (meta_empty)
  );

  assign beat_head        = tag_is_head(pkt_head[TAG_HI -: 2]);
  assign beat_tail        = tag_is_tail(pkt_head[TAG_HI -: 2]);
  assign meta_rsvd_unused = ^meta_rd[DROP_BIT-1:0];

  // Pop decisions; a head beat arriving mid-packet is left in the FIFO for the next packet.
  always_comb begin
    pkt_pop  = 1'b0;
    meta_pop = 1'b0;
    case (state)
      ST_IDLE:          meta_pop = !pkt_empty && !meta_empty;
      ST_SEND, ST_DROP: pkt_pop  = !pkt_empty && !(beat_head && !first_beat);
      default: ;
    endcase
  end

  // Packet FSM with registered output beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      first_beat   <= 1'b0;
      meta_rewrite <= 1'b0;
      meta_dmac    <= '0;
      meta_smac    <= '0;
      o_pkt_valid  <= 1'b0;
      o_pkt        <= '0;
    end else begin
      o_pkt_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (meta_pop) begin
            meta_dmac    <= meta_rd[DMAC_HI -: MAC_W];
            meta_smac    <= meta_rd[SMAC_HI -: MAC_W];
            meta_rewrite <= meta_rd[REWRITE_BIT];
            first_beat   <= 1'b1;
            state        <= meta_rd[DROP_BIT] ? ST_DROP : ST_SEND;
          end
        end
        ST_SEND, ST_DROP: begin
          if (pkt_pop) begin
            first_beat <= 1'b0;
            if (state == ST_SEND) begin
              o_pkt_valid <= 1'b1;
              o_pkt       <= (first_beat && meta_rewrite)
                             ? mac_rewrite(pkt_head, meta_dmac, meta_smac) : pkt_head;
            end
            if (beat_tail) state <= ST_IDLE;
          end else if (!pkt_empty) begin
            // Unexpected head: close the current packet, keep the beat.
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flags: a write lost to a full FIFO with no same-cycle read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_ovf  <= 1'b0;
      o_meta_ovf <= 1'b0;
    end else begin
      if (i_pkt_valid && pkt_full && !pkt_pop)    o_pkt_ovf  <= 1'b1;
      if (i_meta_valid && meta_full && !meta_pop) o_meta_ovf <= 1'b1;
    end
  end

endmodule
